// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Bits needed to hold an iteration count from 0 up to width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring division step on the {A,Q} pair.
module div_nr_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_a_sh;
    logic [WIDTH:0] w_m;
    logic [WIDTH:0] w_a_nxt;

    assign w_a_sh = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_m    = {1'b0, i_m};

    // Negative partial remainder adds the divisor back, otherwise subtract.
    always_comb begin
        w_a_nxt = w_a_sh - w_m;
        if (i_a[WIDTH]) begin
            w_a_nxt = w_a_sh + w_m;
        end
    end

    assign o_a = w_a_nxt;
    assign o_q = {i_q[WIDTH-2:0], ~w_a_nxt[WIDTH]};

endmodule

// File: rtl/seq_divide.sv
// Multi-cycle signed/unsigned non-restoring divider with start/done handshake.
module seq_divide
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic             w_accept;
    logic             w_zero;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH:0]   w_step_a;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_dd_mag;
    logic [WIDTH-1:0] w_dv_mag;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    div_nr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_m (r_m),
        .o_a (w_step_a),
        .o_q (w_step_q)
    );

    // Operand magnitudes; the most-negative pattern maps onto itself as an unsigned value.
    assign w_dd_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dv_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Final restore and sign correction; low WIDTH bits suffice for the restored remainder.
    assign w_rem_mag = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m) : r_a[WIDTH-1:0];
    assign w_quo_fix = r_neg_q ? -r_q : r_q;
    assign w_rem_fix = r_neg_r ? -w_rem_mag : w_rem_mag;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        w_zero      = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Iteration datapath: operand capture and one quotient bit per ITER cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CW'(WIDTH);
            r_a     <= '0;
            r_q     <= w_dd_mag;
            r_m     <= w_dv_mag;
            r_neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= signed_mode & dividend[WIDTH-1];
        end else if (r_state == ITER) begin
            r_cnt   <= r_cnt - CW'(1);
            r_a     <= w_step_a;
            r_q     <= w_step_q;
        end
    end

    // Handshake and result registers; results hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
        end else begin
            r_busy <= (w_state_nxt == ITER) || (w_state_nxt == FIX);
            r_done <= (w_state_nxt == DONE);
            if (w_zero) begin
                r_dbz <= 1'b1;
                r_quo <= '1;
                r_rem <= dividend;
            end else if (r_state == FIX) begin
                r_dbz <= 1'b0;
                r_quo <= w_quo_fix;
                r_rem <= w_rem_fix;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign result      = {r_rem, r_quo};

endmodule

// File: tb/tb_seq_divide.sv
// Directed testbench for seq_divide with WIDTH=32.
module tb_seq_divide;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    seq_divide #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           glitch;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Start one division, scramble inputs after acceptance, optionally pulse start mid-flight.
    task automatic run_div(input logic sm, input logic [W-1:0] dd, input logic [W-1:0] dv,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                           input int lat, input int glitch, input string tag);
        int   n;
        logic got;
        @(negedge clk);
        signed_mode = sm;
        dividend    = dd;
        divisor     = dv;
        start       = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start       = 1'b0;
                signed_mode = ~sm;
                dividend    = ~dd;
                divisor     = dv + 32'd3;
            end
            if (glitch != 0 && n == glitch) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd0;
            end
            if (glitch != 0 && n == glitch + 1) begin
                start = 1'b0;
            end
            if (n == 3 && lat > 3) chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_q"}, 64'(quotient), 64'(q));
        chk({tag, "_r"}, 64'(remainder), 64'(r));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, result, {r, q});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int   n;
        logic got;

        vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34, 0};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34, 0};
        vecs[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34, 0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0, 34, 0};
        vecs[5]  = '{1'b1, 32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0, 34, 0};
        vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1,  0};
        vecs[7]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 0};
        vecs[8]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34, 0};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 34, 0};
        vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 34, 0};
        vecs[11] = '{1'b1, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 34, 0};
        vecs[12] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1,  0};
        vecs[13] = '{1'b0, 32'd1000,       32'd7,          32'd142,        32'd6,          1'b0, 34, 5};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].sm, vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
                    vecs[i].dbz, vecs[i].lat, vecs[i].glitch, $sformatf("v%0d", i));
        end

        // Reset in the middle of a division
        @(negedge clk);
        signed_mode = 1'b0;
        dividend    = 32'd1000;
        divisor     = 32'd7;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_q", 64'(quotient), 64'd0);
        chk("midrst_r", 64'(remainder), 64'd0);
        chk("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34, 0, "after_rst");

        // Back-to-back with start held high
        @(negedge clk);
        signed_mode = 1'b1;
        dividend    = 32'd100;
        divisor     = 32'd7;
        start       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 100) begin
                @(posedge clk);
                #1;
                n++;
                if (done) got = 1'b1;
            end
            chk($sformatf("b2b%0d_done", k), 64'(got), 64'd1);
            chk($sformatf("b2b%0d_lat", k), 64'(n), 64'd34);
            chk($sformatf("b2b%0d_q", k), 64'(quotient), (k == 0) ? 64'd14 : 64'd16);
            chk($sformatf("b2b%0d_r", k), 64'(remainder), 64'd2);
            dividend = 32'd50;
            divisor  = 32'd3;
        end
        @(posedge clk);
        #1;
        chk("b2b_reaccept_busy", 64'(busy), 64'd1);
        chk("b2b_reaccept_done", 64'(done), 64'd0);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
